sayeh_mem_responder: RTL
========================

# sayeh_mem_responder

Memory-side responder for the SAYEH processor bus. It answers the CPU's `ReadMem`/`WriteMem` strobes on `Addressbus`/`Databus` and holds a word-addressed 16-bit RAM. It inserts a configurable number of wait states and then signals completion on `MemDataready`. It sits beside the `Sayeh` top level in system and test benches and replaces behavioural memory models with a synthesizable, cycle-exact slave.

## Interface
- `ADDR_W`, 10: implemented RAM address bits; depth is 2**ADDR_W words.
- `WAIT_STATES`, 2: idle cycles inserted before acknowledge; range 0..15.
- `clk` input 1: single clock; all logic rising-edge.
- `ExternalReset_n` input 1: reset, synchronous and active-low.
- `ReadMem` input 1: read strobe from CPU, level, held until acknowledge.
- `WriteMem` input 1: write strobe from CPU, level, held until acknowledge.
- `Addressbus` input 16: word address.
- `Databus` inout 16: write data from CPU; read data driven by this block only in ACK of a read, otherwise high-Z.
- `MemDataready` output 1: acknowledge, registered.
- `MemError` output 1: present only with `SAYEH_MEM_BOUNDS_CHECK_EN`; registered.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: exactly one strobe high → latch `Addressbus`, latched op (read/write), and `Databus` (writes); load `wcnt`=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACK.
- Both strobes high in IDLE → protocol violation: nothing latched, stay IDLE, no acknowledge.
- WAIT: `wcnt` decrements each cycle; on the cycle `wcnt`==1 → ACK.
- Entry into ACK (same edge):
  - write: RAM[latched addr] ← latched data.
  - read: RAM[latched addr] registered into `rdata`.
- ACK: `MemDataready`=1; for reads, `Databus`=`rdata`. Stay while the latched strobe is high. Strobe low → IDLE, `MemDataready` drops on that edge, `Databus` released combinationally.
- Strobe dropped during WAIT → abort to IDLE, no RAM write, no acknowledge.
- Strobe switching to the other op during WAIT/ACK is ignored; the latched op governs.
- Address mapping (macro off): `Addressbus[ADDR_W-1:0]` used, upper bits ignored (aliasing wrap).
- `ReadIO`/`WriteIO` are not connected; IO space is another block's responsibility.

## Timing
- Strobe sampled at edge N → `MemDataready` high after edge N+1+WAIT_STATES.
- Read data valid on `Databus` in the same cycle as `MemDataready`.
- Write data is sampled once, at edge N. The CPU holds `Databus` only through that edge.
- Minimum request-to-request spacing: one IDLE cycle after the strobe deasserts.
- Reset, any state, at the next edge:
  - state IDLE, `wcnt`=0, `MemDataready`=0, `MemError`=0, `Databus` high-Z.
  - RAM contents preserved.
  - In-flight write not committed unless ACK was already entered.

## Configuration
- `SAYEH_MEM_BOUNDS_CHECK_EN` defined:
  - `MemError` port exists.
  - Latched address with any bit ≥ ADDR_W set → normal wait sequence, then ACK with `MemDataready`=1 and `MemError`=1.
  - Read returns 16'hFFFF; write is dropped.
  - `MemError` follows `MemDataready` timing and clears with it.
- Not defined: no `MemError` port; upper address bits ignored (wrap).

## Structure
- Package `sayeh_bus_pkg`:
  - `SAYEH_DATA_W`=16, `SAYEH_ADDR_W`=16.
  - state enum `mem_state_t` {IDLE, WAIT, ACK}.
  - `MEM_ERR_DATA`=16'hFFFF.
- Sub-module `sayeh_mem_array`: single-port synchronous RAM, ADDR_W × 16, one write enable, registered read. No reset on contents.
- Top holds FSM, wait counter, latches, tri-state driver, bounds check.

## Test plan
- WAIT_STATES=2: write 16'hBEEF to 16'h0010, then read 16'h0010. Expect `MemDataready` 3 cycles after each strobe and `Databus`=16'hBEEF during read ACK.
- WAIT_STATES=0: read 16'h0003 preloaded 16'h1234. Expect ack 1 cycle after the strobe and data 16'h1234; `Databus` Z one cycle after the strobe drops.
- `ReadMem`=`WriteMem`=1 for 5 cycles. Expect no `MemDataready`, `Databus` Z, RAM unchanged.
- Write to 16'h0020, strobe dropped after 1 WAIT cycle. Expect no ack and RAM[16'h0020] unchanged on readback.
- `ExternalReset_n` low during ACK of a read. Expect `MemDataready`=0 and `Databus` Z next edge; a following read returns the prior contents.
- Macro on, ADDR_W=10: read 16'h0400 → `MemError`=1, data 16'hFFFF. Macro off: write 16'h0401 then read 16'h0001 → written value (wrap).

Source files
------------

// File: rtl/sayeh_bus_pkg.sv
// rtl/sayeh_bus_pkg.sv - shared SAYEH bus widths, memory FSM states and helpers
package sayeh_bus_pkg;

    localparam int SAYEH_DATA_W = 16;
    localparam int SAYEH_ADDR_W = 16;

    localparam logic [SAYEH_DATA_W-1:0] MEM_ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } mem_state_t;

    // True when any address bit at or above the implemented RAM width is set.
    function automatic logic addr_out_of_range(input logic [SAYEH_ADDR_W-1:0] addr,
                                               input int                      addr_w);
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/sayeh_mem_array.sv
// rtl/sayeh_mem_array.sv - single-port synchronous RAM, read-first, registered read, no content reset
module sayeh_mem_array
    import sayeh_bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [SAYEH_DATA_W-1:0] wdata,
    output logic [SAYEH_DATA_W-1:0] rdata
);

    logic [SAYEH_DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sayeh_mem_responder.sv
// rtl/sayeh_mem_responder.sv - SAYEH memory slave with wait states; SAYEH_MEM_BOUNDS_CHECK_EN adds MemError
module sayeh_mem_responder
    import sayeh_bus_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    ExternalReset_n,
    input  logic                    ReadMem,
    input  logic                    WriteMem,
    input  logic [SAYEH_ADDR_W-1:0] Addressbus,
    inout  wire  [SAYEH_DATA_W-1:0] Databus,
    output logic                    MemDataready
`ifdef SAYEH_MEM_BOUNDS_CHECK_EN
    ,
    output logic                    MemError
`endif
);

    mem_state_t              state;
    mem_state_t              next_state;
    logic [3:0]              wcnt;
    logic [SAYEH_ADDR_W-1:0] addr_q;
    logic [SAYEH_DATA_W-1:0] wdata_q;
    logic                    wr_q;

    logic                    req_one;
    logic                    held;
    logic                    enter_ack;
    logic                    ack_d;
    logic [SAYEH_ADDR_W-1:0] cur_addr;
    logic [SAYEH_DATA_W-1:0] cur_wdata;
    logic                    cur_wr;
    logic                    cur_err;
    logic [SAYEH_DATA_W-1:0] ram_rdata;
    logic [SAYEH_DATA_W-1:0] rdata_out;

    assign req_one = ReadMem ^ WriteMem;
    assign held    = wr_q ? WriteMem : ReadMem;

    // With zero wait states ACK is entered on the latching edge, so the RAM
    // must see the live bus rather than the (not yet loaded) latches.
    assign cur_addr  = (state == IDLE) ? Addressbus : addr_q;
    assign cur_wdata = (state == IDLE) ? Databus    : wdata_q;
    assign cur_wr    = (state == IDLE) ? WriteMem   : wr_q;

`ifdef SAYEH_MEM_BOUNDS_CHECK_EN
    logic err_q;

    assign cur_err   = addr_out_of_range(cur_addr, ADDR_W);
    assign rdata_out = err_q ? MEM_ERR_DATA : ram_rdata;
`else
    logic unused_addr_hi;

    assign cur_err        = 1'b0;
    assign rdata_out      = ram_rdata;
    assign unused_addr_hi = ^cur_addr[SAYEH_ADDR_W-1:ADDR_W];
`endif

    always_ff @(posedge clk) begin
        if (!ExternalReset_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            MemDataready <= 1'b0;
`ifdef SAYEH_MEM_BOUNDS_CHECK_EN
            MemError     <= 1'b0;
`endif
        end else begin
            state        <= next_state;
            MemDataready <= ack_d;
`ifdef SAYEH_MEM_BOUNDS_CHECK_EN
            MemError     <= ack_d && err_q;
`endif
            if (state == IDLE && req_one) begin
                addr_q  <= Addressbus;
                wr_q    <= WriteMem;
                wdata_q <= Databus;
                wcnt    <= 4'(WAIT_STATES);
`ifdef SAYEH_MEM_BOUNDS_CHECK_EN
                err_q   <= cur_err;
`endif
            end else if (state == WAIT) begin
                wcnt <= held ? wcnt - 4'd1 : '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_one) next_state = (WAIT_STATES > 0) ? WAIT : ACK;
            WAIT: begin
                if (!held) begin
                    next_state = IDLE;
                end else if (wcnt == 4'd1) begin
                    next_state = ACK;
                end
            end
            ACK:     if (!held) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (!ExternalReset_n) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        enter_ack = (next_state == ACK) && (state != ACK);
        ack_d     = (next_state == ACK) && (state == ACK);
    end

    sayeh_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (enter_ack),
        .we    (enter_ack && cur_wr && !cur_err),
        .addr  (cur_addr[ADDR_W-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign Databus = (MemDataready && !wr_q) ? rdata_out : 'z;

endmodule
